dmem_responder: RTL and testbench

//  Data-memory responder for the pipeline MEM-stage request bus (memReq/memWrite/memSize).

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_store_buffer.sv | 69 ++++++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   SZ_B / SZ_H / SZ_W : request size encodings (2'b11 is illegal)
//   sb_entry_t         : store-buffer entry {word address, byte mask, lane-placed data}
//   isMisaligned       : size/offset fault rule
//   byteMask           : byte enables for a size at a byte offset
//   laneData           : right-justified store data replicated onto every lane it may occupy
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offs);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offs[0];
      SZ_W:    bad = (offs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byteMask(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << offs;
      SZ_H:    m = 4'b0011 << offs;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicating the datum onto all lanes avoids a shifter; the byte mask picks the live lane.
  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response bus.
//   i_memReq, i_memWrite, i_memSize, i_addr, i_wdata : request from the pipeline
//   o_ready, o_rdata, o_rvalid, o_fault              : handshake and response from the memory
// master = pipeline side, slave = memory side.
interface dmem_responder_if;
  logic        i_memReq;
  logic        i_memWrite;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_fault;

  modport master (
    output i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
    input  o_ready, o_rdata, o_rvalid, o_fault
  );

  modport slave (
    input  i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
    output o_ready, o_rdata, o_rvalid, o_fault
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: circular FIFO of pending stores.
//   clk, reset_x   : clock, synchronous active-low reset (empties the buffer)
//   push/pushEntry : enqueue at tail (ignored when full)
//   pop            : retire head entry (ignored when empty)
//   queryWaddr     : word address compared against every live entry
//   full, empty    : occupancy flags
//   headEntry      : oldest entry
//   ageEntry       : entries in age order, index 0 = oldest
//   ageMatch       : per age slot, entry live and its word address equals queryWaddr
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                push,
  input  sb_entry_t           pushEntry,
  input  logic                pop,
  input  logic [29:0]         queryWaddr,
  output logic                full,
  output logic                empty,
  output sb_entry_t           headEntry,
  output sb_entry_t           ageEntry [SB_DEPTH],
  output logic [SB_DEPTH-1:0] ageMatch
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  ptr_t      headQ;
  ptr_t      tailQ;
  cnt_t      countQ;
  sb_entry_t slotQ [SB_DEPTH];
  logic      doPush;
  logic      doPop;

  assign full      = (countQ == cnt_t'(SB_DEPTH));
  assign empty     = (countQ == '0);
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headEntry = slotQ[headQ];

  // Pointers wrap naturally because SB_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) tailQ <= tailQ + ptr_t'(1);
      if (doPop)  headQ <= headQ + ptr_t'(1);
      countQ <= countQ + cnt_t'(doPush) - cnt_t'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) slotQ[tailQ] <= pushEntry;
  end

  always_comb begin
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      ageEntry[k] = slotQ[headQ + ptr_t'(k)];
      ageMatch[k] = (cnt_t'(k) < countQ) && (slotQ[headQ + ptr_t'(k)].waddr == queryWaddr);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data memory for the MEM-stage bus, single-port word array behind a store buffer.
//   clk     : clock
//   reset_x : synchronous active-low reset (clears buffer and response flags, not the array)
//   bus     : dmem_responder_if.slave request/response bus
// Stores enter the buffer in one cycle; the head drains in any cycle without an accepted load.
// Responses (o_rvalid / o_fault) are one-cycle pulses the cycle after acceptance.
// Build option DMEM_FWD_EN: loads merge buffered bytes (youngest wins) and are never stalled.
// Without it, a load whose word is still buffered waits (o_ready=0) until those stores drain.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned SB_DEPTH  = 4,
  parameter string       MEM_INIT  = ""
) (
  input logic             clk,
  input logic             reset_x,
  dmem_responder_if.slave bus
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);

  logic [31:0]         memArray [MEM_WORDS];
  logic [AddrW-1:0]    reqIdx;
  logic [1:0]          reqOffs;
  logic                reqFault;
  logic                reqLoad;
  logic                reqStore;
  logic                loadReady;
  logic                ready;
  logic                loadAcc;
  logic                storeAcc;
  logic                faultAcc;
  logic                drain;
  sb_entry_t           pushEntry;
  sb_entry_t           headEntry;
  sb_entry_t           ageEntry [SB_DEPTH];
  logic [SB_DEPTH-1:0] ageMatch;
  logic                sbFull;
  logic                sbEmpty;
  logic [31:0]         rawQ;
  logic [31:0]         mergedWord;
  logic                rvalidQ;
  logic                faultQ;

  // Upper address bits alias onto the array.
  assign reqOffs  = bus.i_addr[1:0];
  assign reqIdx   = bus.i_addr[AddrW+1:2];
  assign reqFault = isMisaligned(bus.i_memSize, reqOffs);
  assign reqLoad  = bus.i_memReq && !bus.i_memWrite && !reqFault;
  assign reqStore = bus.i_memReq && bus.i_memWrite && !reqFault;

  // Faulting requests are always accepted; they touch neither array nor buffer.
  assign ready     = reqFault ? 1'b1 : (bus.i_memWrite ? !sbFull : loadReady);
  assign loadAcc   = reqLoad && ready;
  assign storeAcc  = reqStore && ready;
  assign faultAcc  = bus.i_memReq && reqFault;
  assign bus.o_ready = ready;

  // The array has one port: a load read takes priority over draining the head.
  assign drain = reset_x && !sbEmpty && !loadAcc;

  assign pushEntry = '{
    waddr: 30'(reqIdx),
    mask:  byteMask(bus.i_memSize, reqOffs),
    data:  laneData(bus.i_memSize, bus.i_wdata)
  };

  dmem_store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .reset_x    (reset_x),
    .push       (storeAcc),
    .pushEntry  (pushEntry),
    .pop        (drain),
    .queryWaddr (30'(reqIdx)),
    .full       (sbFull),
    .empty      (sbEmpty),
    .headEntry  (headEntry),
    .ageEntry   (ageEntry),
    .ageMatch   (ageMatch)
  );

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (headEntry.mask[b]) begin
          memArray[headEntry.waddr[AddrW-1:0]][8*b +: 8] <= headEntry.data[8*b +: 8];
        end
      end
    end
    if (loadAcc) rawQ <= memArray[reqIdx];
  end

`ifdef DMEM_FWD_EN
  logic [3:0]  fwdMask;
  logic [3:0]  fwdMaskQ;
  logic [31:0] fwdData;
  logic [31:0] fwdDataQ;

  // Walk entries oldest to youngest so the youngest write to a byte wins.
  always_comb begin
    fwdMask = '0;
    fwdData = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ageMatch[k] && ageEntry[k].mask[b]) begin
          fwdMask[b]          = 1'b1;
          fwdData[8*b +: 8]   = ageEntry[k].data[8*b +: 8];
        end
      end
    end
  end

  // Buffer bytes are captured at accept time and merged with the array word a cycle later.
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      fwdMaskQ <= '0;
      fwdDataQ <= '0;
    end else if (loadAcc) begin
      fwdMaskQ <= fwdMask;
      fwdDataQ <= fwdData;
    end
  end

  always_comb begin
    mergedWord = rawQ;
    for (int unsigned b = 0; b < 4; b++) begin
      if (fwdMaskQ[b]) mergedWord[8*b +: 8] = fwdDataQ[8*b +: 8];
    end
  end

  assign loadReady = 1'b1;
`else
  assign mergedWord = rawQ;
  assign loadReady  = ~|ageMatch;
`endif

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      rvalidQ <= 1'b0;
      faultQ  <= 1'b0;
    end else begin
      rvalidQ <= loadAcc;
      faultQ  <= faultAcc;
    end
  end

  assign bus.o_rvalid = rvalidQ;
  assign bus.o_fault  = faultQ;
  assign bus.o_rdata  = rvalidQ ? mergedWord : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. The reference model keeps a plain word array plus an
// ordered list of pending stores; loads see the array with pending stores applied in order.
module tb_dmem_responder;

  localparam int unsigned Words = 256;
  localparam int unsigned Depth = 4;
`ifdef DMEM_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [3:0]  mask;
    logic [31:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .MEM_WORDS (Words),
    .SB_DEPTH  (Depth),
    .MEM_INIT  ("")
  ) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  logic [31:0] refMem [Words];
  pend_t       pend [$];
  int          nCmp = 0;
  int          nBad = 0;
  int          traceErr = 0;
  bit          expRvalid;
  bit          expFault;
  logic [31:0] expData;

  function automatic logic [31:0] initVal(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
  endfunction

  // One bus cycle: drive, sample ready mid-cycle, advance the model, sample the response.
  task automatic step(input bit req, input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output bit acc);
    bit          flt;
    bit          ld;
    bit          st;
    bit          er;
    bit          hit;
    int          idx;
    int          offs;
    logic [3:0]  m;
    logic [31:0] w;
    bit          nv;
    bit          nf;
    bus.i_memReq   = req;
    bus.i_memWrite = wr;
    bus.i_memSize  = sz;
    bus.i_addr     = addr;
    bus.i_wdata    = wd;
    @(negedge clk);
    offs = int'(addr[1:0]);
    flt  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && offs != 0);
    idx  = int'(addr[9:2]);
    hit  = 1'b0;
    foreach (pend[i]) if (pend[i].idx == idx) hit = 1'b1;
    if (flt)     er = 1'b1;
    else if (wr) er = (pend.size() < Depth);
    else         er = Fwd ? 1'b1 : !hit;
    acc = req && reset_x && er;
    if (req && reset_x && bus.o_ready !== er) traceErr++;
    ld = acc && !wr && !flt;
    st = acc && wr && !flt;
    w  = refMem[idx];
    foreach (pend[i]) begin
      if (pend[i].idx == idx) begin
        for (int b = 0; b < 4; b++) if (pend[i].mask[b]) w[8*b +: 8] = pend[i].data[8*b +: 8];
      end
    end
    nv = ld;
    nf = acc && flt;
    if (!reset_x) begin
      pend.delete();
      nv = 1'b0;
      nf = 1'b0;
    end else begin
      if (!ld && pend.size() > 0) begin
        for (int b = 0; b < 4; b++) begin
          if (pend[0].mask[b]) refMem[pend[0].idx][8*b +: 8] = pend[0].data[8*b +: 8];
        end
        void'(pend.pop_front());
      end
      if (st) begin
        case (sz)
          2'b00:   m = 4'b0001 << offs;
          2'b01:   m = 4'b0011 << offs;
          default: m = 4'b1111;
        endcase
        pend.push_back('{idx: idx, mask: m, data: wd << (8 * offs)});
      end
    end
    @(posedge clk);
    #1;
    expRvalid = nv;
    expFault  = nf;
    if (nv) expData = w;
    if (bus.o_rvalid !== nv || bus.o_fault !== nf || (nv && bus.o_rdata !== w)) traceErr++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, acc);
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 16 && !acc; n++) step(1'b1, 1'b1, sz, addr, wd, acc);
    if (!acc) traceErr++;
  endtask

  task automatic doLoad(input logic [31:0] addr, output logic [31:0] data, output bit vld,
                        output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    for (int n = 0; n < 16 && !acc; n++) begin
      step(1'b1, 1'b0, 2'b10, addr, 32'h0, acc);
      if (!acc) stalls++;
    end
    if (!acc) traceErr++;
    data = bus.o_rdata;
    vld  = bus.o_rvalid;
  endtask

  task automatic test_reset();
    reset_x = 1'b0;
    idle(2);
    nCmp++;
    if (bus.o_rvalid !== 1'b0 || bus.o_fault !== 1'b0 || bus.o_rdata !== 32'h0) begin
      nBad++;
      $display("FAIL reset_outputs: rvalid=%b fault=%b rdata=%h, want 0 0 00000000",
               bus.o_rvalid, bus.o_fault, bus.o_rdata);
    end
    reset_x = 1'b1;
    #1;
    nCmp++;
    if (bus.o_ready !== 1'b1) begin
      nBad++;
      $display("FAIL reset_ready: got %b want 1", bus.o_ready);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < Words; i++) doStore(32'(i * 4), 2'b10, initVal(i));
    idle(3);
    nCmp++;
    if (traceErr !== 0) begin
      nBad++;
      $display("FAIL init_trace: %0d cycle errors, want 0", traceErr);
    end
    traceErr = 0;
  endtask

  task automatic test_forward();
    logic [31:0] d;
    bit          v;
    int          s;
    doStore(32'h100, 2'b10, 32'hDEAD_BEEF);
    doLoad(32'h100, d, v, s);
    nCmp++;
    if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin
      nBad++;
      $display("FAIL fwd_data: rvalid=%b rdata=%h, want 1 deadbeef", v, d);
    end
    nCmp++;
    if (s !== (Fwd ? 0 : 1)) begin
      nBad++;
      $display("FAIL fwd_stall: got %0d stall cycles want %0d", s, Fwd ? 0 : 1);
    end
    idle(1);
    nCmp++;
    if (bus.o_rvalid !== 1'b0) begin
      nBad++;
      $display("FAIL rvalid_pulse: rvalid=%b one cycle later, want 0", bus.o_rvalid);
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] d;
    bit          v;
    int          s;
    doStore(32'h100, 2'b10, 32'h1122_3344);
    doStore(32'h101, 2'b00, 32'hFFFF_FFAA);
    doLoad(32'h100, d, v, s);
    nCmp++;
    if (v !== 1'b1 || d !== 32'h1122_AA44) begin
      nBad++;
      $display("FAIL byte_merge_buffered: rvalid=%b rdata=%h, want 1 1122aa44", v, d);
    end
    idle(4);
    doLoad(32'h100, d, v, s);
    nCmp++;
    if (v !== 1'b1 || d !== 32'h1122_AA44) begin
      nBad++;
      $display("FAIL byte_merge_drained: rvalid=%b rdata=%h, want 1 1122aa44", v, d);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d;
    logic [31:0] want [4];
    bit          v;
    int          s;
    logic [31:0] sa [5];
    logic [1:0]  sz [5];
    logic [31:0] sd [5];
    sa = '{32'h200, 32'h204, 32'h208, 32'h202, 32'h20C};
    sz = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    sd = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0000_00EE, 32'h0D0E_0F10};
    want = '{32'h01EE_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    for (int i = 0; i < 5; i++) begin
      doStore(sa[i], sz[i], sd[i]);
      doLoad(32'h000, d, v, s);
    end
    idle(6);
    for (int i = 0; i < 4; i++) begin
      doLoad(32'h200 + 32'(4 * i), d, v, s);
      nCmp++;
      if (v !== 1'b1 || d !== want[i]) begin
        nBad++;
        $display("FAIL fill_word%0d: rvalid=%b rdata=%h, want 1 %h", i, v, d, want[i]);
      end
    end
    nCmp++;
    if (traceErr !== 0) begin
      nBad++;
      $display("FAIL fill_trace: %0d cycle errors, want 0", traceErr);
    end
    traceErr = 0;
  endtask

  task automatic test_fault();
    logic [31:0] d;
    bit          v;
    int          s;
    bit          acc;
    step(1'b1, 1'b0, 2'b01, 32'h103, 32'h0, acc);
    nCmp++;
    if (bus.o_fault !== 1'b1 || bus.o_rvalid !== 1'b0) begin
      nBad++;
      $display("FAIL fault_half: fault=%b rvalid=%b, want 1 0", bus.o_fault, bus.o_rvalid);
    end
    idle(1);
    nCmp++;
    if (bus.o_fault !== 1'b0) begin
      nBad++;
      $display("FAIL fault_pulse: fault=%b, want 0", bus.o_fault);
    end
    step(1'b1, 1'b1, 2'b11, 32'h100, 32'hFFFF_FFFF, acc);
    nCmp++;
    if (bus.o_fault !== 1'b1 || bus.o_rvalid !== 1'b0) begin
      nBad++;
      $display("FAIL fault_size11: fault=%b rvalid=%b, want 1 0", bus.o_fault, bus.o_rvalid);
    end
    step(1'b1, 1'b1, 2'b10, 32'h102, 32'h5555_5555, acc);
    nCmp++;
    if (bus.o_fault !== 1'b1) begin
      nBad++;
      $display("FAIL fault_word: fault=%b, want 1", bus.o_fault);
    end
    idle(3);
    doLoad(32'h100, d, v, s);
    nCmp++;
    if (d !== 32'h1122_AA44) begin
      nBad++;
      $display("FAIL fault_no_effect: rdata=%h, want 1122aa44", d);
    end
  endtask

  task automatic test_reset_pending();
    logic [31:0] d;
    bit          v;
    int          s;
    idle(2);
    doStore(32'h300, 2'b10, 32'hCAFE_F00D);
    reset_x = 1'b0;
    idle(2);
    reset_x = 1'b1;
    nCmp++;
    if (bus.o_rvalid !== 1'b0 || bus.o_fault !== 1'b0) begin
      nBad++;
      $display("FAIL rst_flags: rvalid=%b fault=%b, want 0 0", bus.o_rvalid, bus.o_fault);
    end
    doLoad(32'h300, d, v, s);
    nCmp++;
    if (v !== 1'b1 || d !== initVal(192)) begin
      nBad++;
      $display("FAIL rst_discard: rvalid=%b rdata=%h, want 1 %h", v, d, initVal(192));
    end
  endtask

  task automatic test_halves();
    logic [31:0] d;
    bit          v;
    int          s;
    doStore(32'h3F0, 2'b01, 32'h0000_BEEF);
    doStore(32'h3F2, 2'b01, 32'hFFFF_1234);
    doStore(32'h3F1, 2'b00, 32'h0000_0077);
    doLoad(32'h3F0, d, v, s);
    nCmp++;
    if (v !== 1'b1 || d !== 32'h1234_77EF) begin
      nBad++;
      $display("FAIL halves_merge: rvalid=%b rdata=%h, want 1 123477ef", v, d);
    end
    idle(4);
    doLoad(32'h3F0, d, v, s);
    nCmp++;
    if (d !== 32'h1234_77EF) begin
      nBad++;
      $display("FAIL halves_drained: rdata=%h, want 123477ef", d);
    end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    bit          v;
    int          s;
    doStore(32'h104 + 32'(Words * 4), 2'b10, 32'h5A5A_A5A5);
    doLoad(32'h104, d, v, s);
    nCmp++;
    if (d !== 32'h5A5A_A5A5) begin
      nBad++;
      $display("FAIL alias: rdata=%h, want 5a5aa5a5", d);
    end
  endtask

  task automatic test_random();
    bit          acc;
    int          r;
    int          szSel;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 600; i++) begin
      r     = $urandom_range(0, 9);
      szSel = $urandom_range(0, 7);
      sz    = (szSel < 2) ? 2'b00 : (szSel < 4) ? 2'b01 : (szSel < 7) ? 2'b10 : 2'b11;
      addr  = 32'h500 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      addr  = addr | (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 1)) << 20);
      if (r < 2)      step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, acc);
      else if (r < 6) step(1'b1, 1'b0, sz, addr, 32'h0, acc);
      else            step(1'b1, 1'b1, sz, addr, $urandom, acc);
      nCmp++;
      if (bus.o_rvalid !== expRvalid || bus.o_fault !== expFault) begin
        nBad++;
        $display("FAIL rnd_flags[%0d]: rvalid=%b fault=%b, want %b %b", i, bus.o_rvalid,
                 bus.o_fault, expRvalid, expFault);
      end
      if (expRvalid) begin
        nCmp++;
        if (bus.o_rdata !== expData) begin
          nBad++;
          $display("FAIL rnd_data[%0d]: rdata=%h, want %h", i, bus.o_rdata, expData);
        end
      end
    end
    nCmp++;
    if (traceErr !== 0) begin
      nBad++;
      $display("FAIL rnd_ready_trace: %0d cycle errors, want 0", traceErr);
    end
    traceErr = 0;
  endtask

  initial begin
    bus.i_memReq   = 1'b0;
    bus.i_memWrite = 1'b0;
    bus.i_memSize  = 2'b00;
    bus.i_addr     = 32'h0;
    bus.i_wdata    = 32'h0;
    test_reset();
    test_init();
    test_forward();
    test_byte_merge();
    test_fill();
    test_fault();
    test_reset_pending();
    test_halves();
    test_alias();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
